// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Shared definitions for the four-lane filter dot-product engine.
//   DATA_WIDTH_DEF : signed element width
//   ELEMENTS_DEF   : elements per vector (power of two)
//   ACC_WIDTH_DEF  : accumulator width, 2*DATA_WIDTH + log2(ELEMENTS)
//   LANES          : number of filter lanes (b0..b3)
//   dot_state_e    : control FSM state encoding
// -----------------------------------------------------------------------------
package filter_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ELEMENTS_DEF   = 16;
   localparam int ACC_WIDTH_DEF  = 36;
   localparam int LANES          = 4;

   // IDLE  : counter at 0, no partial sum held
   // ACCUM : 1..ELEMENTS-1 pairs of the current vector taken
   // FLUSH : last product of a vector is sitting in the product registers
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FLUSH = 2'd2
   } dot_state_e;

endpackage

// File: rtl/filter_mac_lane.sv
// -----------------------------------------------------------------------------
// filter_mac_lane
// One multiply-accumulate lane: registers a*b (full signed product), then
// sign-extends it and either loads or adds it into the accumulator.
// Ports:
//   clock, clear  : clock and synchronous active-high clear
//   mul_en_i      : capture a_i*b_i into the product register
//   a_i, b_i      : signed operands
//   acc_en_i      : product register holds a valid product this cycle
//   acc_load_i    : product starts a new vector (load instead of add)
//   sum_o         : accumulator value after this cycle's update
// -----------------------------------------------------------------------------
module filter_mac_lane
   import filter_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
   input  logic                         clock,
   input  logic                         clear,
   input  logic                         mul_en_i,
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   input  logic                         acc_en_i,
   input  logic                         acc_load_i,
   output logic signed [ACC_WIDTH-1:0]  sum_o
);

   localparam int PW = 2 * DATA_WIDTH;

   logic [PW-1:0]               a_ext;
   logic [PW-1:0]               b_ext;
   logic signed [PW-1:0]        prod_d;
   logic signed [PW-1:0]        prod_q;
   logic signed [ACC_WIDTH-1:0] prod_ext;
   logic signed [ACC_WIDTH-1:0] acc_d;
   logic signed [ACC_WIDTH-1:0] acc_q;

   // Operands are sign-extended to the product width; the low PW bits of the
   // product are then the exact two's-complement signed product.
   assign a_ext  = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
   assign b_ext  = {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
   assign prod_d = $signed(a_ext * b_ext);

   assign prod_ext = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};

   // First product of a vector overwrites the old sum, so a new vector can
   // start the cycle right after the previous one ends.
   always_comb begin
      acc_d = acc_q;
      if (acc_en_i) begin
         if (acc_load_i) begin
            acc_d = prod_ext;
         end else begin
            acc_d = acc_q + prod_ext;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         prod_q <= '0;
         acc_q  <= '0;
      end else begin
         if (mul_en_i) begin
            prod_q <= prod_d;
         end
         acc_q <= acc_d;
      end
   end

   assign sum_o = acc_d;

endmodule

// File: rtl/filter_dot_product.sv
// -----------------------------------------------------------------------------
// filter_dot_product
// Four parallel dot products of one input vector against four filter vectors.
// Each accepted element pair is multiplied in four lanes, registered, then
// accumulated; completed sums are published two cycles after the last accept.
// Optional feature: define FILTER_DOT_RELU_EN to clamp negative results to 0
// (same latency either way).
// Ports:
//   clock               : clock, all logic on posedge
//   clear               : synchronous active-high reset
//   en                  : stage enable; low freezes counter and FSM
//   a_valid, a_element  : input-vector element and its valid
//   b_elements_ready    : b0..b3 elements valid this cycle
//   b0..b3_element      : signed filter elements
//   result0..result3    : signed dot products, held until the next pulse
//   result_valid        : one-cycle pulse when result0..3 update
//   busy                : a vector is partially accumulated
// Handshake: a pair is taken in any cycle where en && a_valid &&
// b_elements_ready and clear is low; there is no backpressure.
// -----------------------------------------------------------------------------
module filter_dot_product
   import filter_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ELEMENTS   = ELEMENTS_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
   input  logic                         clock,
   input  logic                         clear,
   input  logic                         en,
   input  logic                         a_valid,
   input  logic signed [DATA_WIDTH-1:0] a_element,
   input  logic                         b_elements_ready,
   input  logic signed [DATA_WIDTH-1:0] b0_element,
   input  logic signed [DATA_WIDTH-1:0] b1_element,
   input  logic signed [DATA_WIDTH-1:0] b2_element,
   input  logic signed [DATA_WIDTH-1:0] b3_element,
   output logic signed [ACC_WIDTH-1:0]  result0,
   output logic signed [ACC_WIDTH-1:0]  result1,
   output logic signed [ACC_WIDTH-1:0]  result2,
   output logic signed [ACC_WIDTH-1:0]  result3,
   output logic                         result_valid,
   output logic                         busy
);

   localparam int                CNT_W    = $clog2(ELEMENTS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ELEMENTS - 1);

   logic                         accept;
   dot_state_e                   state_q;
   dot_state_e                   state_d;
   logic [CNT_W-1:0]             cnt_q;
   logic [CNT_W-1:0]             cnt_d;

   // Control travelling alongside the product registers.
   logic                         prod_vld_q;
   logic                         prod_first_q;
   logic                         prod_last_q;

   logic signed [DATA_WIDTH-1:0] b_w      [LANES];
   logic signed [ACC_WIDTH-1:0]  sum_w    [LANES];
   logic signed [ACC_WIDTH-1:0]  res_d    [LANES];
   logic signed [ACC_WIDTH-1:0]  result_q [LANES];
   logic                         result_valid_q;
   logic                         publish;

   // A pair offered in the same cycle as clear is dropped.
   assign accept = en && a_valid && b_elements_ready && !clear;

   assign b_w[0] = b0_element;
   assign b_w[1] = b1_element;
   assign b_w[2] = b2_element;
   assign b_w[3] = b3_element;

   // ---------------------------------------------------------------------
   // Control FSM and element counter
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (accept) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
         case (state_q)
            ST_IDLE:  state_d = ST_ACCUM;
            ST_ACCUM: state_d = (cnt_q == CNT_LAST) ? ST_FLUSH : ST_ACCUM;
            ST_FLUSH: state_d = ST_ACCUM;
            default:  state_d = ST_IDLE;
         endcase
      end else if (en && (state_q == ST_FLUSH)) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         prod_vld_q   <= 1'b0;
         prod_first_q <= 1'b0;
         prod_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prod_vld_q <= accept;
         if (accept) begin
            prod_first_q <= (cnt_q == '0);
            prod_last_q  <= (cnt_q == CNT_LAST);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Four MAC lanes sharing control
   // ---------------------------------------------------------------------
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      filter_mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
         .clock      (clock),
         .clear      (clear),
         .mul_en_i   (accept),
         .a_i        (a_element),
         .b_i        (b_w[g]),
         .acc_en_i   (prod_vld_q),
         .acc_load_i (prod_first_q),
         .sum_o      (sum_w[g])
      );
   end

   // ---------------------------------------------------------------------
   // Result registers: loaded with the completed sums as the last product
   // is accumulated, so the pulse lands two cycles after the last accept.
   // ---------------------------------------------------------------------
   assign publish = prod_vld_q && prod_last_q;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
`ifdef FILTER_DOT_RELU_EN
         res_d[i] = sum_w[i][ACC_WIDTH-1] ? '0 : sum_w[i];
`else
         res_d[i] = sum_w[i];
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         result_valid_q <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            result_q[i] <= '0;
         end
      end else begin
         result_valid_q <= publish;
         if (publish) begin
            for (int i = 0; i < LANES; i++) begin
               result_q[i] <= res_d[i];
            end
         end
      end
   end

   assign result0      = result_q[0];
   assign result1      = result_q[1];
   assign result2      = result_q[2];
   assign result3      = result_q[3];
   assign result_valid = result_valid_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_filter_dot_product.sv
// -----------------------------------------------------------------------------
// tb_filter_dot_product
// Directed bench for filter_dot_product with default parameters.
// Build with FILTER_DOT_RELU_EN defined to check the clamped variant.
// -----------------------------------------------------------------------------
module tb_filter_dot_product;

   logic               clock;
   logic               clear;
   logic               en;
   logic               a_valid;
   logic signed [15:0] a_element;
   logic               b_elements_ready;
   logic signed [15:0] b0_element;
   logic signed [15:0] b1_element;
   logic signed [15:0] b2_element;
   logic signed [15:0] b3_element;
   logic signed [35:0] result0;
   logic signed [35:0] result1;
   logic signed [35:0] result2;
   logic signed [35:0] result3;
   logic               result_valid;
   logic               busy;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   filter_dot_product dut (
      .clock            (clock),
      .clear            (clear),
      .en               (en),
      .a_valid          (a_valid),
      .a_element        (a_element),
      .b_elements_ready (b_elements_ready),
      .b0_element       (b0_element),
      .b1_element       (b1_element),
      .b2_element       (b2_element),
      .b3_element       (b3_element),
      .result0          (result0),
      .result1          (result1),
      .result2          (result2),
      .result3          (result3),
      .result_valid     (result_valid),
      .busy             (busy)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic accept_pair(input logic signed [15:0] a, input logic signed [15:0] b0,
                              input logic signed [15:0] b1, input logic signed [15:0] b2,
                              input logic signed [15:0] b3);
      en               = 1'b1;
      a_valid          = 1'b1;
      b_elements_ready = 1'b1;
      a_element        = a;
      b0_element       = b0;
      b1_element       = b1;
      b2_element       = b2;
      b3_element       = b3;
      step();
   endtask

   task automatic idle_cycle();
      en      = 1'b1;
      a_valid = 1'b0;
      step();
   endtask

   task automatic do_clear();
      clear   = 1'b1;
      a_valid = 1'b0;
      step();
      clear   = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      en = 1'b1; a_valid = 1'b1; b_elements_ready = 1'b1;
      a_element = 16'sd7; b0_element = 16'sd3; b1_element = -16'sd2;
      b2_element = 16'sd1; b3_element = 16'sd9;
      clear = 1'b1;
      step();
      step();
      clear = 1'b0;
      a_valid = 1'b0;
      chk_cnt++; if (result_valid !== 1'b0) $display("FAIL reset_rv: got %0b expected 0", result_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else pass_cnt++;
      chk_cnt++; if (result0 !== 36'sd0) $display("FAIL reset_r0: got %0d expected 0", result0); else pass_cnt++;
      chk_cnt++; if (result3 !== 36'sd0) $display("FAIL reset_r3: got %0d expected 0", result3); else pass_cnt++;
      step();
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_accept_ignored: busy got %0b expected 0", busy); else pass_cnt++;
   endtask

   task automatic test_basic();
      logic signed [35:0] exp2;
`ifdef FILTER_DOT_RELU_EN
      exp2 = 36'sd0;
`else
      exp2 = -36'sd16;
`endif
      do_clear();
      for (int i = 0; i < 16; i++) accept_pair(16'sd1, 16'sd1, 16'sd2, -16'sd1, 16'sd0);
      a_valid = 1'b0;
      chk_cnt++; if (result_valid !== 1'b0) $display("FAIL basic_rv_early: got %0b expected 0", result_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_flush: got %0b expected 1", busy); else pass_cnt++;
      step();
      chk_cnt++; if (result_valid !== 1'b1) $display("FAIL basic_rv: got %0b expected 1", result_valid); else pass_cnt++;
      chk_cnt++; if (result0 !== 36'sd16) $display("FAIL basic_r0: got %0d expected 16", result0); else pass_cnt++;
      chk_cnt++; if (result1 !== 36'sd32) $display("FAIL basic_r1: got %0d expected 32", result1); else pass_cnt++;
      chk_cnt++; if (result2 !== exp2) $display("FAIL basic_r2: got %0d expected %0d", result2, exp2); else pass_cnt++;
      chk_cnt++; if (result3 !== 36'sd0) $display("FAIL basic_r3: got %0d expected 0", result3); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_idle: got %0b expected 0", busy); else pass_cnt++;
      step();
      step();
      chk_cnt++; if (result_valid !== 1'b0) $display("FAIL basic_rv_pulse: got %0b expected 0", result_valid); else pass_cnt++;
      chk_cnt++; if (result0 !== 36'sd16) $display("FAIL basic_hold_r0: got %0d expected 16", result0); else pass_cnt++;
      chk_cnt++; if (result1 !== 36'sd32) $display("FAIL basic_hold_r1: got %0d expected 32", result1); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      do_clear();
      for (int i = 0; i < 32; i++) begin
         if (i < 16) accept_pair(16'sd2, 16'sd3, 16'sd0, 16'sd0, 16'sd0);
         else        accept_pair(-16'sd1, 16'sd5, 16'sd0, 16'sd0, 16'sd0);
         chk_cnt++;
         if (result_valid !== (i == 16)) $display("FAIL b2b_rv_%0d: got %0b expected %0b", i, result_valid, (i == 16));
         else pass_cnt++;
         chk_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy_%0d: got %0b expected 1", i, busy); else pass_cnt++;
         if (i == 16) begin
            chk_cnt++; if (result0 !== 36'sd96) $display("FAIL b2b_r0_first: got %0d expected 96", result0); else pass_cnt++;
         end
      end
      a_valid = 1'b0;
      step();
      chk_cnt++; if (result_valid !== 1'b1) $display("FAIL b2b_rv_second: got %0b expected 1", result_valid); else pass_cnt++;
      chk_cnt++; if (result0 !== -36'sd80) $display("FAIL b2b_r0_second: got %0d expected -80", result0); else pass_cnt++;
      step();
      chk_cnt++; if (result_valid !== 1'b0) $display("FAIL b2b_rv_end: got %0b expected 0", result_valid); else pass_cnt++;
   endtask

   task automatic test_toggle();
      logic signed [35:0] exp0;
      exp0 = 36'sh3_FFF0_0010;  // 16 * 0x3FFF0001
      do_clear();
      for (int i = 0; i < 32; i++) begin
         if ((i % 2) == 0) accept_pair(16'sh7FFF, 16'sh7FFF, 16'sd0, 16'sd0, 16'sd0);
         else              idle_cycle();
         chk_cnt++;
         if (result_valid !== (i == 31)) $display("FAIL toggle_rv_%0d: got %0b expected %0b", i, result_valid, (i == 31));
         else pass_cnt++;
         if (i < 31) begin
            chk_cnt++; if (busy !== 1'b1) $display("FAIL toggle_busy_%0d: got %0b expected 1", i, busy); else pass_cnt++;
         end
      end
      chk_cnt++; if (result0 !== exp0) $display("FAIL toggle_r0: got %0d expected %0d", result0, exp0); else pass_cnt++;
   endtask

   task automatic test_clear_mid();
      for (int i = 0; i < 7; i++) accept_pair(16'sd1, 16'sd5, 16'sd1, 16'sd1, 16'sd1);
      // clear with a pair offered in the same cycle
      clear = 1'b1;
      step();
      clear = 1'b0;
      a_valid = 1'b0;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL clr_busy: got %0b expected 0", busy); else pass_cnt++;
      chk_cnt++; if (result_valid !== 1'b0) $display("FAIL clr_rv: got %0b expected 0", result_valid); else pass_cnt++;
      chk_cnt++; if (result0 !== 36'sd0) $display("FAIL clr_r0: got %0d expected 0", result0); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         idle_cycle();
         chk_cnt++; if (result_valid !== 1'b0) $display("FAIL clr_no_pulse_%0d: got %0b expected 0", i, result_valid); else pass_cnt++;
      end
      for (int i = 0; i < 16; i++) accept_pair(16'sd1, 16'sd1, 16'sd0, 16'sd0, 16'sd0);
      a_valid = 1'b0;
      chk_cnt++; if (result_valid !== 1'b0) $display("FAIL clr_rv_early: got %0b expected 0", result_valid); else pass_cnt++;
      step();
      chk_cnt++; if (result_valid !== 1'b1) $display("FAIL clr_rv_after: got %0b expected 1", result_valid); else pass_cnt++;
      chk_cnt++; if (result0 !== 36'sd16) $display("FAIL clr_r0_after: got %0d expected 16", result0); else pass_cnt++;
   endtask

   task automatic test_en_freeze();
      do_clear();
      for (int i = 0; i < 8; i++) accept_pair(16'sd3, -16'sd2, 16'sd0, 16'sd0, 16'sd0);
      en = 1'b0;  // a_valid and b_elements_ready stay high
      for (int i = 0; i < 5; i++) begin
         step();
         chk_cnt++; if (busy !== 1'b1) $display("FAIL en_busy_%0d: got %0b expected 1", i, busy); else pass_cnt++;
         chk_cnt++; if (result_valid !== 1'b0) $display("FAIL en_rv_%0d: got %0b expected 0", i, result_valid); else pass_cnt++;
      end
      for (int i = 0; i < 8; i++) accept_pair(16'sd3, -16'sd2, 16'sd0, 16'sd0, 16'sd0);
      a_valid = 1'b0;
      chk_cnt++; if (result_valid !== 1'b0) $display("FAIL en_rv_early: got %0b expected 0", result_valid); else pass_cnt++;
      step();
      chk_cnt++; if (result_valid !== 1'b1) $display("FAIL en_rv_final: got %0b expected 1", result_valid); else pass_cnt++;
      chk_cnt++; if (result0 !== -36'sd96) $display("FAIL en_r0: got %0d expected -96", result0); else pass_cnt++;
   endtask

   task automatic test_extreme();
      logic signed [35:0] exp0;
      logic signed [35:0] exp1;
      exp0 = 36'sh4_0000_0000;  // 16 * 2^30 = 2^34
`ifdef FILTER_DOT_RELU_EN
      exp1 = 36'sd0;
`else
      exp1 = -36'sd17179344896;  // 16 * (-32768 * 32767)
`endif
      do_clear();
      for (int i = 0; i < 16; i++) accept_pair(-16'sd32768, -16'sd32768, 16'sd32767, 16'sd0, 16'sd0);
      a_valid = 1'b0;
      step();
      chk_cnt++; if (result_valid !== 1'b1) $display("FAIL ext_rv: got %0b expected 1", result_valid); else pass_cnt++;
      chk_cnt++; if (result0 !== exp0) $display("FAIL ext_r0: got %0d expected %0d", result0, exp0); else pass_cnt++;
      chk_cnt++; if (result1 !== exp1) $display("FAIL ext_r1: got %0d expected %0d", result1, exp1); else pass_cnt++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      clear = 1'b1; en = 1'b0; a_valid = 1'b0; b_elements_ready = 1'b0;
      a_element = '0; b0_element = '0; b1_element = '0; b2_element = '0; b3_element = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_toggle();
      test_clear_mid();
      test_en_freeze();
      test_extreme();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
